// File: rtl/dual_opl_mixer_if.sv
// dual_opl_mixer_if
// Groups the sample-side and output-side signals of the dual OPL mixer.
//   snd1, snd2   : signed 16-bit samples from the two YM3526 cores
//   sample       : sample strobe; its rising edge marks a new snd1/snd2 pair
//   vol1, vol2   : unsigned 4-bit channel gains (0 = silent, 15 = max)
//   mute         : forces the mixed value to zero for captured samples
//   clip_clr     : clears the sticky clip flag
//   snd_out      : signed 16-bit mixed sample, held between updates
//   out_valid    : one-cycle pulse when snd_out updates
//   clip         : sticky saturation flag
// master drives the inputs (sound source / bench); slave is the mixer.
interface dual_opl_mixer_if;
    logic signed [15:0] snd1;
    logic signed [15:0] snd2;
    logic               sample;
    logic        [3:0]  vol1;
    logic        [3:0]  vol2;
    logic               mute;
    logic               clip_clr;
    logic signed [15:0] snd_out;
    logic               out_valid;
    logic               clip;

    modport master (
        output snd1, snd2, sample, vol1, vol2, mute, clip_clr,
        input  snd_out, out_valid, clip
    );

    modport slave (
        input  snd1, snd2, sample, vol1, vol2, mute, clip_clr,
        output snd_out, out_valid, clip
    );
endinterface

// File: rtl/dual_opl_mixer.sv
// dual_opl_mixer
// Mixes the outputs of two YM3526 cores with per-channel gain, saturates the
// sum to 16 bits and optionally smooths it with a one-pole low-pass filter.
// Ports:
//   clk  : system clock, all logic on its rising edge
//   rst  : synchronous active-high reset
//   bus  : dual_opl_mixer_if.slave (samples, gains, mute, clip_clr in;
//          snd_out, out_valid, clip out)
// Parameter:
//   LPF_SHIFT : filter coefficient as a right shift, legal range 1..6
// Build option:
//   DUAL_OPL_MIXER_LPF_EN : when defined, adds filter stage S3 and output
//                           appears 3 clocks after the edge; otherwise the
//                           saturated mix is output 2 clocks after the edge.
module dual_opl_mixer #(
    parameter int unsigned LPF_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    dual_opl_mixer_if.slave   bus
);

    if (LPF_SHIFT < 1 || LPF_SHIFT > 6) begin : g_bad_lpf_shift
        $error("dual_opl_mixer: LPF_SHIFT must be in 1..6");
    end

    // Resets high so a strobe already high at reset release is not an edge.
    logic sample_r;
    logic smp_edge;
    assign smp_edge = bus.sample & ~sample_r;

    // S0 capture registers
    logic               s0_valid;
    logic signed [15:0] s0_snd1;
    logic signed [15:0] s0_snd2;
    logic        [3:0]  s0_vol1;
    logic        [3:0]  s0_vol2;
    logic               s0_mute;

    // S1 product registers
    logic               s1_valid;
    logic signed [20:0] s1_p1;
    logic signed [20:0] s1_p2;
    logic               s1_mute;

    // S2 combinational mix and saturation
    logic signed [21:0] s2_sum;
    logic signed [21:0] s2_shift;
    logic signed [15:0] s2_res;
    logic               s2_sat;

    logic               sat_r;
    logic               clip_r;
    logic               out_valid_r;
    logic signed [15:0] out_r;

    assign bus.snd_out   = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.clip      = clip_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_r <= 1'b1;
            s0_valid <= 1'b0;
            s0_snd1  <= '0;
            s0_snd2  <= '0;
            s0_vol1  <= '0;
            s0_vol2  <= '0;
            s0_mute  <= 1'b0;
            s1_valid <= 1'b0;
            s1_p1    <= '0;
            s1_p2    <= '0;
            s1_mute  <= 1'b0;
        end else begin
            sample_r <= bus.sample;
            s0_valid <= smp_edge;
            if (smp_edge) begin
                s0_snd1 <= bus.snd1;
                s0_snd2 <= bus.snd2;
                s0_vol1 <= bus.vol1;
                s0_vol2 <= bus.vol2;
                s0_mute <= bus.mute;
            end
            s1_valid <= s0_valid;
            s1_mute  <= s0_mute;
            // Gains are zero-extended so 8..15 stay positive multipliers.
            s1_p1    <= 21'(s0_snd1) * 21'($signed({1'b0, s0_vol1}));
            s1_p2    <= 21'(s0_snd2) * 21'($signed({1'b0, s0_vol2}));
        end
    end

    always_comb begin
        s2_sum   = 22'(s1_p1) + 22'(s1_p2);
        s2_shift = s2_sum >>> 3;
        s2_res   = s2_shift[15:0];
        s2_sat   = 1'b0;
        if (s1_mute) begin
            s2_res = '0;
        end else if (s2_shift > 22'sd32767) begin
            s2_res = 16'sh7fff;
            s2_sat = 1'b1;
        end else if (s2_shift < -22'sd32768) begin
            s2_res = 16'sh8000;
            s2_sat = 1'b1;
        end
    end

    // Saturation is registered first, so clip rises one clock after S2.
    // A new saturation wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_r  <= 1'b0;
            clip_r <= 1'b0;
        end else begin
            sat_r <= s1_valid & s2_sat;
            if (sat_r) begin
                clip_r <= 1'b1;
            end else if (bus.clip_clr) begin
                clip_r <= 1'b0;
            end
        end
    end

`ifdef DUAL_OPL_MIXER_LPF_EN
    logic               x_valid;
    logic signed [15:0] x_r;
    logic signed [16:0] lpf_diff;
    logic signed [16:0] lpf_step;

    // y moves a fraction of the way toward x, so y + step never leaves
    // the 16-bit range even though the difference needs 17 bits.
    always_comb begin
        lpf_diff = 17'(x_r) - 17'(out_r);
        lpf_step = lpf_diff >>> LPF_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_valid     <= 1'b0;
            x_r         <= '0;
            out_valid_r <= 1'b0;
            out_r       <= '0;
        end else begin
            x_valid     <= s1_valid;
            if (s1_valid) begin
                x_r <= s2_res;
            end
            out_valid_r <= x_valid;
            if (x_valid) begin
                out_r <= out_r + lpf_step[15:0];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_r       <= '0;
        end else begin
            out_valid_r <= s1_valid;
            if (s1_valid) begin
                out_r <= s2_res;
            end
        end
    end
`endif

endmodule

// File: doc/dual_opl_mixer.md
DUAL_OPL_MIXER -- requirements
Module: dual_opl_mixer

Interface
REQ-001 LPF_SHIFT, 2, one-pole low-pass coefficient as a right shift; legal range 1..6.
REQ-002 clk  input  1  system clock (53.6MHz); all logic on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 snd1  input  16  signed sample from first YM3526 (jtopl).
REQ-005 snd2  input  16  signed sample from second YM3526 (jtopl).
REQ-006 sample  input  1  sample strobe from first YM3526; rising edge marks a new snd1/snd2 pair.
REQ-007 vol1  input  4  unsigned gain for snd1; 0 silences the channel, 15 is maximum.
REQ-008 vol2  input  4  unsigned gain for snd2; same encoding as vol1.
REQ-009 mute  input  1  high forces the mixed value to 0 for captured samples.
REQ-010 clip_clr  input  1  clears the clip flag.
REQ-011 snd_out  output  16  signed mixed (and filtered) sample, held between updates.
REQ-012 out_valid  output  1  one-clk pulse when snd_out updates.
REQ-013 clip  output  1  sticky saturation flag.

Function
REQ-014 Edge detect SHALL use register sample_r: edge = sample & ~sample_r, sampled every clk.
REQ-015 Stage S0 (edge cycle T) SHALL capture snd1, snd2, vol1, vol2 and mute into pipeline registers.
REQ-016 Stage S1 (T+1) SHALL compute p1 = snd1*vol1 and p2 = snd2*vol2, each 21-bit signed, with vol zero-extended to 5-bit signed.
REQ-017 Stage S2 (T+2) SHALL form s = (p1+p2) as 22-bit signed, arithmetic-shift it right by 3, and saturate it to [-32768, 32767].
REQ-018 If mute is captured high, S2 SHALL produce 0 and SHALL NOT set clip.
REQ-019 Saturation in S2 SHALL set clip at T+3; clip SHALL stay high until clip_clr=1 for a clk.
REQ-020 clip_clr and a new saturation in the same cycle SHALL leave clip=1 (set wins).
REQ-021 The pipeline SHALL be fully pipelined: back-to-back edges 2 clk apart SHALL each produce one out_valid pulse with no loss.
REQ-022 out_valid SHALL pulse once per detected edge, at the latency defined under Configuration.
REQ-023 snd_out SHALL change only in the cycle out_valid is high.
REQ-024 sample held high continuously SHALL yield exactly one edge.

Reset
REQ-025 rst SHALL clear all pipeline registers, snd_out=0, out_valid=0, clip=0, and the filter state=0.
REQ-026 rst SHALL set sample_r=1 so that sample high at reset release produces no spurious edge.
REQ-027 An edge in flight when rst asserts SHALL be discarded, with no out_valid after release.

Configuration
REQ-028 With macro DUAL_OPL_MIXER_LPF_EN defined, stage S3 (T+3) SHALL compute y <= y + ((x - y) >>> LPF_SHIFT), with 17-bit signed difference and 16-bit signed y.
REQ-029 With the macro defined, snd_out = y and out_valid SHALL fire at T+3.
REQ-030 Without the macro, S3 and the filter state SHALL be absent; snd_out = S2 result and out_valid SHALL fire at T+2.

Verification
REQ-031 LPF off; vol1=vol2=8, snd1=1000, snd2=2000, one edge -> snd_out=3000, out_valid exactly 2 clk after the edge, clip=0.
REQ-032 vol1=vol2=15, snd1=snd2=32767 -> snd_out=32767, clip=1 and stays high; clip_clr pulse -> clip=0. Repeat with -32768 -> snd_out=-32768.
REQ-033 LPF on, LPF_SHIFT=2; vol1=8, vol2=0, snd1=4000, three edges -> snd_out 1000, 1750, 2312; out_valid 3 clk after each edge.
REQ-034 mute=1, vol1=vol2=15, snd1=snd2=32767 -> LPF off: snd_out=0, clip=0. LPF on: output decays toward 0 with no clip.
REQ-035 Edges 2 clk apart with snd1=100,200,300, vol1=8, vol2=0, LPF off -> three out_valid pulses, snd_out 100, 200, 300 in order.
REQ-036 sample high through rst, rst asserted 1 clk after an edge -> no out_valid after release, all outputs 0 until the next true rising edge.
